// File: rtl/shifter_arbiter_if.sv
// Requester-side bundle for shifter_arbiter: two request ports and a shared
// response bus with per-port valid/ready.
interface shifter_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_op0;
  logic [1:0]         req_op1;
  logic [SHAMT_W-1:0] req_shamt0;
  logic [SHAMT_W-1:0] req_shamt1;
  logic [DATA_W-1:0]  req_data0;
  logic [DATA_W-1:0]  req_data1;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;

  // Requesters drive requests and response acceptance.
  modport master (
    output req_valid, req_op0, req_op1, req_shamt0, req_shamt1,
           req_data0, req_data1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // The arbiter accepts requests and produces responses.
  modport slave (
    input  req_valid, req_op0, req_op1, req_shamt0, req_shamt1,
           req_data0, req_data1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Shares one combinational shifter between two requesters. One transaction
// is in flight at a time: IDLE (grant/accept) -> EXEC (shifter evaluates)
// -> RESP (hold result until the owner accepts it).
module shifter_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter bit RR_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  shifter_arbiter_if.slave   bus,
  output logic [1:0]         sh_S,
  output logic [SHAMT_W-1:0] sh_shift,
  output logic [DATA_W-1:0]  sh_B,
  input  logic [DATA_W-1:0]  sh_H
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_ILLEGAL = 2'b01;

  state_t            state, state_nxt;
  logic              rr_last;
  logic              owner;
  logic              err_pend;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [1:0]        grant;
  logic              win;
  logic              accept;

  // Grant selection and FSM next state; the grant only exists in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    grant     = 2'b00;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid == 2'b11) begin
          if (RR_EN) grant = rr_last ? 2'b01 : 2'b10;
          else       grant = 2'b01;
        end else begin
          grant = bus.req_valid;
        end
        if (grant != 2'b00) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign win    = grant[1];
  assign accept = (grant != 2'b00);

  // Handshake outputs; gated by rst_n so reset forces them low immediately.
  assign bus.req_ready = rst_n ? grant : 2'b00;
  assign bus.rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q & (state == RESP);

  // State register and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      owner   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= win;
        rr_last <= win;
      end
    end
  end

  // Operand capture on accept and result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, because the shifter inputs
    // and rsp_data are visible ports whose reset value is defined as zero.
    if (!rst_n) begin
      sh_S       <= 2'b00;
      sh_shift   <= '0;
      sh_B       <= '0;
      err_pend   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        sh_S     <= win ? bus.req_op1    : bus.req_op0;
        sh_shift <= win ? bus.req_shamt1 : bus.req_shamt0;
        sh_B     <= win ? bus.req_data1  : bus.req_data0;
        err_pend <= (win ? bus.req_op1 : bus.req_op0) == OP_ILLEGAL;
      end
      if (state == EXEC) begin
        // Illegal ops return the operand untouched.
        rsp_data_q <= err_pend ? sh_B : sh_H;
        rsp_err_q  <= err_pend;
      end
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: a round-robin instance covers the main
// flows, a fixed-priority instance covers RR_EN=0. A behavioural shifter
// drives sh_H of each instance.
module tb_shifter_arbiter;
  localparam int DW = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shifter_arbiter_if #(.DATA_W(DW), .SHAMT_W(SW)) bus ();
  shifter_arbiter_if #(.DATA_W(DW), .SHAMT_W(SW)) fp ();

  logic [1:0]    sh_S, fp_S;
  logic [SW-1:0] sh_shift, fp_shift;
  logic [DW-1:0] sh_B, sh_H, fp_B, fp_H;

  // Reference shifter; illegal op yields a marker value that must never reach rsp_data.
  function automatic logic [DW-1:0] shf(input logic [1:0] s, input logic [SW-1:0] n,
                                        input logic [DW-1:0] b);
    case (s)
      2'b00:   return b << n;
      2'b10:   return b >> n;
      2'b11:   return $signed(b) >>> n;
      default: return 32'hA5A5_A5A5;
    endcase
  endfunction

  assign sh_H = shf(sh_S, sh_shift, sh_B);
  assign fp_H = shf(fp_S, fp_shift, fp_B);

  shifter_arbiter #(.DATA_W(DW), .SHAMT_W(SW), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .sh_S(sh_S), .sh_shift(sh_shift), .sh_B(sh_B), .sh_H(sh_H)
  );

  shifter_arbiter #(.DATA_W(DW), .SHAMT_W(SW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(fp.slave),
    .sh_S(fp_S), .sh_shift(fp_shift), .sh_B(fp_B), .sh_H(fp_H)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_op0 = 2'b00; bus.req_op1 = 2'b00;
    bus.req_shamt0 = '0; bus.req_shamt1 = '0;
    bus.req_data0 = '0; bus.req_data1 = '0;
    fp.req_valid = 2'b00; fp.rsp_ready = 2'b00;
    fp.req_op0 = 2'b00; fp.req_op1 = 2'b00;
    fp.req_shamt0 = '0; fp.req_shamt1 = '0;
    fp.req_data0 = '0; fp.req_data1 = '0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_data !== 32'h0 ||
        bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h err=%b want 00 00 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    checks++;
    if (sh_S !== 2'b00 || sh_shift !== 5'd0 || sh_B !== 32'h0) begin
      errors++;
      $display("FAIL reset_operands: S=%b shift=%0d B=%h want 00 0 0", sh_S, sh_shift, sh_B);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_port0_sll();
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01; bus.req_op0 = 2'b00; bus.req_shamt0 = 5'd4; bus.req_data0 = 32'h0000_00F1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL p0_grant: got %b want 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00; bus.req_data0 = 32'hFFFF_FFFF;
    checks++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || sh_B !== 32'h0000_00F1 ||
        sh_shift !== 5'd4) begin
      errors++;
      $display("FAIL p0_exec: rdy=%b vld=%b B=%h shift=%0d want 00 00 000000f1 4",
               bus.req_ready, bus.rsp_valid, sh_B, sh_shift);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'h0000_0F10 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL p0_resp: vld=%b data=%h err=%b want 01 00000f10 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL p0_done: vld=%b want 00", bus.rsp_valid);
    end
  endtask

  task automatic test_port1_sra_srl();
    logic [1:0]    ops [2] = '{2'b11, 2'b10};
    logic [DW-1:0] exp [2] = '{32'hFF80_0012, 32'h0080_0012};
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 2'b10; bus.req_op1 = ops[i]; bus.req_shamt1 = 5'd8;
      bus.req_data1 = 32'h8000_1234;
      #1;
      checks++;
      if (bus.req_ready !== 2'b10) begin
        errors++; $display("FAIL p1_grant[%0d]: got %b want 10", i, bus.req_ready);
      end
      tick();
      bus.req_valid = 2'b00;
      tick();
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== exp[i] || bus.rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL p1_resp[%0d]: vld=%b data=%h err=%b want 10 %h 0",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    bus.rsp_ready = 2'b11;
    bus.req_op0 = 2'b00; bus.req_shamt0 = 5'd1; bus.req_data0 = 32'd1;
    bus.req_op1 = 2'b10; bus.req_shamt1 = 5'd1; bus.req_data1 = 32'd4;
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (bus.req_ready !== g) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_ready, g);
      end
      tick();
      tick();
      checks++;
      if (bus.rsp_valid !== g || bus.rsp_data !== 32'h2) begin
        errors++;
        $display("FAIL rr_resp[%0d]: vld=%b data=%h want %b 00000002", i, bus.rsp_valid,
                 bus.rsp_data, g);
      end
      tick();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    // Last grant was port 1, so port 0 wins with both valid.
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b11;
    bus.req_shamt0 = 5'd3;  // 1 << 3 = 8
    #1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.rsp_ready = (i % 2 == 0) ? 2'b00 : 2'b10;  // non-owner ready is ignored
      bus.req_data0 = 32'h5555_0000 + i;
      #1;
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'h8 || bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b data=%h rdy=%b want 01 00000008 00",
                 i, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 2'b01;
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b want 00 10", bus.rsp_valid, bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'h2) begin
      errors++;
      $display("FAIL bp_next: vld=%b data=%h want 10 00000002", bus.rsp_valid, bus.rsp_data);
    end
    bus.rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_illegal_op();
    bus.req_valid = 2'b01; bus.req_op0 = 2'b01; bus.req_shamt0 = 5'd3;
    bus.req_data0 = 32'hDEAD_BEEF;
    tick();
    bus.req_valid = 2'b00;
    checks++;
    if (sh_S !== 2'b01) begin
      errors++; $display("FAIL ill_sh_S: got %b want 01", sh_S);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ill_resp: vld=%b err=%b data=%h want 01 1 deadbeef",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    tick();
    // Legal follow-up with shamt=0: operand returned unchanged, no error.
    bus.req_valid = 2'b10; bus.req_op1 = 2'b11; bus.req_shamt1 = 5'd0;
    bus.req_data1 = 32'h8765_4321;
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h8765_4321) begin
      errors++;
      $display("FAIL legal_after_ill: vld=%b err=%b data=%h want 10 0 87654321",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    tick();
    bus.req_data1 = 32'h0;
    bus.req_op1 = 2'b00;
    tick();
    checks++;
    if (sh_B !== 32'h8765_4321 || sh_S !== 2'b11) begin
      errors++;
      $display("FAIL operand_hold: B=%h S=%b want 87654321 11", sh_B, sh_S);
    end
  endtask

  task automatic test_async_reset();
    bus.req_valid = 2'b01; bus.req_op0 = 2'b00; bus.req_shamt0 = 5'd2; bus.req_data0 = 32'h3;
    tick();  // now in EXEC
    bus.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 || sh_B !== 32'h0 ||
        bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: vld=%b rdy=%b B=%h data=%h want 00 00 0 0",
               bus.rsp_valid, bus.req_ready, sh_B, bus.rsp_data);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL post_reset_grant: got %b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    fp.rsp_ready = 2'b11;
    fp.req_op0 = 2'b00; fp.req_shamt0 = 5'd2; fp.req_data0 = 32'h3;
    fp.req_op1 = 2'b10; fp.req_shamt1 = 5'd1; fp.req_data1 = 32'h8;
    fp.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (fp.req_ready !== 2'b01) begin
        errors++; $display("FAIL fp_grant[%0d]: got %b want 01", i, fp.req_ready);
      end
      tick();
      tick();
      checks++;
      if (fp.rsp_valid !== 2'b01 || fp.rsp_data !== 32'hC) begin
        errors++;
        $display("FAIL fp_resp[%0d]: vld=%b data=%h want 01 0000000c", i, fp.rsp_valid,
                 fp.rsp_data);
      end
      tick();
    end
    fp.req_valid = 2'b10;
    #1;
    checks++;
    if (fp.req_ready !== 2'b10) begin
      errors++; $display("FAIL fp_single_p1: got %b want 10", fp.req_ready);
    end
    fp.req_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_port0_sll();
    test_port1_sra_srl();
    test_round_robin();
    test_backpressure();
    test_illegal_op();
    test_async_reset();
    test_fixed_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
